train_sequencer: RTL and testbench

Top-level training scheduler for the network layer chain (BiasWeight and peer layers). Drives the shared mode (iMode) and learning-rate (iLR) inputs, gates the sample stream into the network, and counts update completions. Runs NE training epochs of NS samples, decaying LR per epoch, then one test pass of NT samples. Never changes mode or LR while samples are in flight.

---
 rtl/train_sequencer_pkg.sv | 17 +
 rtl/train_sequencer_inflight_counter.sv | 45 ++++
 rtl/train_sequencer.sv | 156 +++++++++++++++
 tb/tb_train_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/train_sequencer_pkg.sv
// Shared encodings for the training sequencer and the layer chain it drives:
// layer mode values and the sequencer state set.
package train_sequencer_pkg;

    localparam logic MODE_TEST  = 1'b0;
    localparam logic MODE_TRAIN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRAIN   = 3'd1,
        ST_DRAIN_T = 3'd2,
        ST_TEST    = 3'd3,
        ST_DRAIN_E = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/train_sequencer_inflight_counter.sv
// Up/down count of samples issued into the network but not yet retired.
// Saturates at MAXOUT and never underflows below zero.
module inflight_counter
    import train_sequencer_pkg::*;
#(
    parameter  int MAXOUT = 4,
    localparam int CW     = $clog2(MAXOUT + 1)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [CW-1:0] count_q, count_d;
    logic          do_inc, do_dec;

    // A retire at zero is dropped, so an issue in that same cycle still counts.
    always_comb begin
        do_dec  = dec_i && (count_q != '0);
        do_inc  = inc_i && ((count_q != CW'(MAXOUT)) || do_dec);
        count_d = count_q;
        if (do_inc && !do_dec) begin
            count_d = count_q + 1'b1;
        end else if (do_dec && !do_inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CW'(MAXOUT));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/train_sequencer.sv
// Training scheduler: drives mode and learning rate to the layer chain, gates
// the sample stream and waits for all in-flight samples before any change.
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter  int                    WD       = 8,
    parameter  int                    WF       = 4,
    parameter  int                    NS       = 16,
    parameter  int                    NE       = 4,
    parameter  int                    NT       = 8,
    parameter  int                    MAXOUT   = 4,
    parameter  logic signed [WF-1:0]  LR_INIT  = 4'sb0100,
    parameter  int                    LR_SHIFT = 1,
    parameter  logic signed [WF-1:0]  LR_MIN   = 4'sb0001,
    localparam int                    EW       = $clog2(NE + 1)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iStart,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oMode,
    output logic signed [WF-1:0] oLR,
    output logic [EW-1:0]        oEpoch,
    input  logic                 iValid_AS_Sample,
    output logic                 oReady_AS_Sample,
    input  logic [WD-1:0]        iData_AS_Sample,
    output logic                 oValid_BM_Sample,
    input  logic                 iReady_BM_Sample,
    output logic [WD-1:0]        oData_BM_Sample,
    input  logic                 iValid_AS_Retire,
    output logic                 oReady_AS_Retire
);

    localparam int NMAX = (NS > NT) ? NS : NT;
    localparam int CNTW = $clog2(NMAX + 1);
    localparam int OW   = $clog2(MAXOUT + 1);

    seq_state_e           state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [EW-1:0]        epoch_q, epoch_d;
    logic signed [WF-1:0] lr_q, lr_d;
    logic                 mode_q, mode_d;
    logic                 gate, issue, below_limit;
    logic                 full, empty;
    logic [OW-1:0]        outstanding;

    function automatic logic signed [WF-1:0] lr_decay(input logic signed [WF-1:0] lr);
        logic signed [WF-1:0] shifted;
        shifted = lr >>> LR_SHIFT;
        return (shifted < LR_MIN) ? LR_MIN : shifted;
    endfunction

    inflight_counter #(.MAXOUT(MAXOUT)) u_inflight (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .inc_i   (issue),
        .dec_i   (iValid_AS_Retire),
        .count_o (outstanding),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            epoch_q <= '0;
            lr_q    <= LR_INIT;
            mode_q  <= MODE_TEST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epoch_q <= epoch_d;
            lr_q    <= lr_d;
            mode_q  <= mode_d;
        end
    end

    always_ff @(posedge iCLK) begin
        assert (NE > 0) else $error("train_sequencer: NE must be at least 1");
        if (!iRST) begin
            assert (outstanding <= OW'(MAXOUT)) else $error("train_sequencer: in-flight overflow");
        end
    end

    // Mode and LR only move on drain-complete edges, so no sample sees a change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epoch_d = epoch_q;
        lr_d    = lr_q;
        mode_d  = mode_q;
        if (issue) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_TRAIN;
                    cnt_d   = '0;
                    epoch_d = '0;
                    lr_d    = LR_INIT;
                    mode_d  = MODE_TRAIN;
                end
            end
            ST_TRAIN: begin
                if (issue && (cnt_q == CNTW'(NS - 1))) state_d = ST_DRAIN_T;
            end
            ST_DRAIN_T: begin
                if (empty) begin
                    cnt_d = '0;
                    if (epoch_q == EW'(NE - 1)) begin
                        state_d = ST_TEST;
                        mode_d  = MODE_TEST;
                    end else begin
                        state_d = ST_TRAIN;
                        epoch_d = epoch_q + 1'b1;
                        lr_d    = lr_decay(lr_q);
                    end
                end
            end
            ST_TEST: begin
                if (issue && (cnt_q == CNTW'(NT - 1))) state_d = ST_DRAIN_E;
            end
            ST_DRAIN_E: begin
                if (empty) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        below_limit = 1'b0;
        gate        = 1'b0;
        case (state_q)
            ST_TRAIN: below_limit = (cnt_q < CNTW'(NS));
            ST_TEST:  below_limit = (cnt_q < CNTW'(NT));
            default:  below_limit = 1'b0;
        endcase
        gate             = below_limit && !full;
        oValid_BM_Sample = iValid_AS_Sample && gate;
        oReady_AS_Sample = iReady_BM_Sample && gate;
        issue            = iValid_AS_Sample && iReady_BM_Sample && gate;
        oBusy            = (state_q != ST_IDLE);
        oDone            = (state_q == ST_DONE);
    end

    assign oMode            = mode_q;
    assign oLR              = lr_q;
    assign oEpoch           = epoch_q;
    assign oData_BM_Sample  = iData_AS_Sample;
    assign oReady_AS_Retire = !iRST;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: two configurations share one clock and
// reset; expected values are hand-derived from the sequencer's rules.
module tb_train_sequencer;
    import train_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Configuration A: NS=4 NE=2 NT=2 MAXOUT=4 LR 0100 >>>1
    logic              stA, vA, rdyA, rtA, autoA;
    logic [7:0]        dA, doA;
    logic              busyA, doneA, modeA, rdyOutA, vldOutA, retRdyA, retA;
    logic signed [3:0] lrA;
    logic [1:0]        epA;
    logic [2:0]        histA = '0;
    int                nA = 0;

    // Configuration B: NS=8 NE=3 NT=2 MAXOUT=4 LR 0010 >>>2
    logic              stB, vB, rdyB, rtB;
    logic [7:0]        dB, doB;
    logic              busyB, doneB, modeB, rdyOutB, vldOutB, retRdyB;
    logic signed [3:0] lrB;
    logic [1:0]        epB;
    int                nB = 0;

    assign retA = autoA ? histA[2] : rtA;

    always @(posedge clk) begin
        histA <= {histA[1:0], vldOutA & rdyA};
        if (vldOutA && rdyA) nA <= nA + 1;
        if (vldOutB && rdyB) nB <= nB + 1;
    end

    train_sequencer #(.WD(8), .WF(4), .NS(4), .NE(2), .NT(2), .MAXOUT(4),
                      .LR_INIT(4'sb0100), .LR_SHIFT(1), .LR_MIN(4'sb0001)) u_a (
        .iCLK(clk), .iRST(rst), .iStart(stA), .oBusy(busyA), .oDone(doneA),
        .oMode(modeA), .oLR(lrA), .oEpoch(epA),
        .iValid_AS_Sample(vA), .oReady_AS_Sample(rdyOutA), .iData_AS_Sample(dA),
        .oValid_BM_Sample(vldOutA), .iReady_BM_Sample(rdyA), .oData_BM_Sample(doA),
        .iValid_AS_Retire(retA), .oReady_AS_Retire(retRdyA)
    );

    train_sequencer #(.WD(8), .WF(4), .NS(8), .NE(3), .NT(2), .MAXOUT(4),
                      .LR_INIT(4'sb0010), .LR_SHIFT(2), .LR_MIN(4'sb0001)) u_b (
        .iCLK(clk), .iRST(rst), .iStart(stB), .oBusy(busyB), .oDone(doneB),
        .oMode(modeB), .oLR(lrB), .oEpoch(epB),
        .iValid_AS_Sample(vB), .oReady_AS_Sample(rdyOutB), .iData_AS_Sample(dB),
        .oValid_BM_Sample(vldOutB), .iReady_BM_Sample(rdyB), .oData_BM_Sample(doB),
        .iValid_AS_Retire(rtB), .oReady_AS_Retire(retRdyB)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int        baseA, baseB, dones;
    bit        seen1, seenT, doneSeen;
    logic [3:0] lr1, lrT;
    logic [1:0] epT;
    logic [3:0] lrE [3];
    bit         seenE [3];

    initial begin
        rst = 1'b1;
        {stA, vA, rdyA, rtA, autoA, stB, vB, rdyB, rtB} = '0;
        dA = 8'h00;
        dB = 8'h00;
        step();
        step();

        chk("rstA_busy", busyA, 0);
        chk("rstA_done", doneA, 0);
        chk("rstA_mode", modeA, MODE_TEST);
        chk("rstA_lr", lrA, 4'b0100);
        chk("rstA_epoch", epA, 0);
        chk("rstA_valid", vldOutA, 0);
        chk("rstA_ready", rdyOutA, 0);
        chk("rstB_lr", lrB, 4'b0010);
        chk("rst_retire_ready", retRdyA, 0);

        rst = 1'b0;
        dA  = 8'hA5;
        step();
        chk("data_pass", doA, 8'hA5);
        chk("retire_ready", retRdyA, 1);

        // Issue and retire together, then an epoch boundary with samples in flight.
        baseA = nA;
        vA = 1'b1; rdyA = 1'b1; stA = 1'b1;
        step();
        stA = 1'b0;
        chk("startA_busy", busyA, 1);
        chk("startA_mode", modeA, MODE_TRAIN);
        chk("startA_valid", vldOutA, 1);
        step();
        step();
        chk("out_after2", u_a.u_inflight.count_o, 2);
        rtA = 1'b1;
        step();
        chk("out_iss_ret", u_a.u_inflight.count_o, 2);
        rtA = 1'b0;
        step();
        chk("drainT_valid", vldOutA, 0);
        chk("drainT_out", u_a.u_inflight.count_o, 3);
        chk("drainT_issues", nA - baseA, 4);
        rtA = 1'b1;
        step();
        chk("bnd_mode_a", modeA, MODE_TRAIN);
        chk("bnd_lr_a", lrA, 4'b0100);
        chk("bnd_ep_a", epA, 0);
        step();
        chk("bnd_lr_b", lrA, 4'b0100);
        chk("bnd_valid_b", vldOutA, 0);
        step();
        chk("bnd_out0", u_a.u_inflight.count_o, 0);
        chk("bnd_ep_c", epA, 0);
        chk("bnd_lr_c", lrA, 4'b0100);
        step();
        chk("underflow", u_a.u_inflight.count_o, 0);
        chk("ep1", epA, 1);
        chk("ep1_lr", lrA, 4'b0010);
        chk("ep1_mode", modeA, MODE_TRAIN);
        chk("no_early_issue", nA - baseA, 4);
        chk("ep1_valid", vldOutA, 1);
        rtA = 1'b0;

        // Reset in the middle of training with three samples outstanding.
        step();
        step();
        step();
        chk("pre_rst_out", u_a.u_inflight.count_o, 3);
        rst = 1'b1;
        step();
        chk("mid_rst_busy", busyA, 0);
        chk("mid_rst_mode", modeA, MODE_TEST);
        chk("mid_rst_lr", lrA, 4'b0100);
        chk("mid_rst_ep", epA, 0);
        chk("mid_rst_out", u_a.u_inflight.count_o, 0);
        chk("mid_rst_valid", vldOutA, 0);
        rst = 1'b0;
        rtA = 1'b1;
        step();
        step();
        chk("stray_retire", u_a.u_inflight.count_o, 0);
        chk("idle_ready", rdyOutA, 0);
        rtA = 1'b0;

        // Full run with retire three cycles after each issue.
        baseA = nA;
        autoA = 1'b1;
        stA = 1'b1;
        step();
        stA = 1'b0;
        seen1 = 0; seenT = 0; dones = 0;
        lr1 = '0; lrT = '0; epT = '0;
        for (int i = 0; i < 150; i++) begin
            stA = (i == 5);
            step();
            if (!seen1 && epA == 2'd1) begin seen1 = 1; lr1 = lrA; end
            if (!seenT && busyA && modeA == MODE_TEST) begin seenT = 1; epT = epA; lrT = lrA; end
            if (doneA) dones++;
            if (dones > 0 && !busyA) break;
        end
        stA = 1'b0;
        chk("run_done_pulses", dones, 1);
        chk("run_issues", nA - baseA, 10);
        chk("run_ep1_lr", lr1, 4'b0010);
        chk("run_test_seen", seenT, 1);
        chk("run_test_ep", epT, 1);
        chk("run_test_lr", lrT, 4'b0010);
        chk("run_end_busy", busyA, 0);
        chk("run_end_lr", lrA, 4'b0010);
        chk("run_end_ep", epA, 1);
        chk("run_end_mode", modeA, MODE_TEST);

        // Retire withheld: MAXOUT stalls the stream, one retire admits one issue.
        baseB = nB;
        vB = 1'b1; rdyB = 1'b1; stB = 1'b1;
        step();
        stB = 1'b0;
        chk("B_ep0_lr", lrB, 4'b0010);
        chk("B_ep0", epB, 0);
        for (int i = 0; i < 4; i++) step();
        chk("B_full_valid", vldOutB, 0);
        chk("B_full_ready", rdyOutB, 0);
        chk("B_full_busy", busyB, 1);
        step();
        step();
        chk("B_stall_valid", vldOutB, 0);
        chk("B_stall_issues", nB - baseB, 4);
        rtB = 1'b1;
        step();
        rtB = 1'b0;
        chk("B_one_valid", vldOutB, 1);
        chk("B_one_ready", rdyOutB, 1);
        step();
        chk("B_refull_valid", vldOutB, 0);
        step();
        step();
        chk("B_one_issue", nB - baseB, 5);

        // Let B finish with retire held high and record LR per epoch.
        rtB = 1'b1;
        doneSeen = 0;
        for (int e = 0; e < 3; e++) begin seenE[e] = 0; lrE[e] = '0; end
        for (int i = 0; i < 300; i++) begin
            step();
            if (epB < 2'd3 && busyB && modeB == MODE_TRAIN && !seenE[epB]) begin
                seenE[epB] = 1;
                lrE[epB] = lrB;
            end
            if (doneB) doneSeen = 1;
            if (doneSeen && !busyB) break;
        end
        rtB = 1'b0;
        chk("B_lr_e0", lrE[0], 4'b0010);
        chk("B_lr_e1", lrE[1], 4'b0001);
        chk("B_lr_e2", lrE[2], 4'b0001);
        chk("B_done", doneSeen, 1);
        chk("B_total_issues", nB - baseB, 26);
        chk("B_end_ep", epB, 2);
        chk("B_end_busy", busyB, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
